// File: rtl/neuron_layer_pkg.sv
// Shared definitions for the neuron layer controller: FSM states,
// CTRL/STATUS bit positions and the register-map base offsets.
package neuron_layer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int ADDR_CTRL   = 0;
    localparam int ADDR_STATUS = 1;
    localparam int IN_BASE     = 2;

    localparam int CTRL_SRST  = 0;
    localparam int CTRL_START = 1;

    localparam int ST_IDLE = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_TO   = 3;
    localparam int ST_WERR = 4;

    function automatic int W_BASE(input int ni);
        return IN_BASE + ni;
    endfunction

    function automatic int B_BASE(input int ni, input int nn);
        return W_BASE(ni) + nn * ni;
    endfunction

    function automatic int R_BASE(input int ni, input int nn);
        return B_BASE(ni, nn) + nn;
    endfunction

endpackage

// File: rtl/neuron_layer_ctrl_if.sv
// Register port between the SCI slave network interface (master) and the
// controller (slave).
// Handshake: a request (WREQ/RREQ) is taken in the single cycle it is high;
// the slave always accepts and answers with a one-cycle WACK/RVALID pulse
// exactly one cycle later. RDATA holds its value until the next read.
interface neuron_layer_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int WIDTH      = 8
) ();
    logic                  WREQ;
    logic [ADDR_WIDTH-1:0] WADDR;
    logic [WIDTH-1:0]      WDATA;
    logic                  WACK;
    logic                  RREQ;
    logic [ADDR_WIDTH-1:0] RADDR;
    logic [WIDTH-1:0]      RDATA;
    logic                  RVALID;

    modport master (output WREQ, WADDR, WDATA, RREQ, RADDR,
                    input  WACK, RDATA, RVALID);
    modport slave  (input  WREQ, WADDR, WDATA, RREQ, RADDR,
                    output WACK, RDATA, RVALID);
endinterface

// File: rtl/neuron_layer_regbank.sv
// Register file for the neuron layer: inputs, weights, biases, results,
// CTRL soft-reset level and the sticky write-error flag. Also drives the
// core-facing operand muxes for the neuron selected by idx.
module neuron_layer_regbank import neuron_layer_pkg::*; #(
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_NEURONS = 4,
    parameter int WIDTH       = 8,
    parameter int ADDR_WIDTH  = 6,
    parameter int IDX_W       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    neuron_layer_ctrl_if.slave          bus,
    input  logic                        busy,
    input  logic                        idle,
    input  logic                        st_done,
    input  logic                        st_ovf,
    input  logic                        st_to,
    input  logic [IDX_W-1:0]            idx,
    input  logic                        res_we,
    input  logic [WIDTH-1:0]            res_data,
    output logic                        soft_reset,
    output logic                        start_req,
    output logic [NUM_INPUTS*WIDTH-1:0] core_weights,
    output logic [WIDTH-1:0]            core_bias,
    output logic [NUM_INPUTS*WIDTH-1:0] core_values
);
    localparam int WB = W_BASE(NUM_INPUTS);
    localparam int BB = B_BASE(NUM_INPUTS, NUM_NEURONS);
    localparam int RB = R_BASE(NUM_INPUTS, NUM_NEURONS);

    logic [WIDTH-1:0] in_q  [NUM_INPUTS],  in_d  [NUM_INPUTS];
    logic [WIDTH-1:0] w_q   [NUM_NEURONS*NUM_INPUTS], w_d [NUM_NEURONS*NUM_INPUTS];
    logic [WIDTH-1:0] b_q   [NUM_NEURONS], b_d   [NUM_NEURONS];
    logic [WIDTH-1:0] res_q [NUM_NEURONS], res_d [NUM_NEURONS];
    logic             srst_q, srst_d, err_q, err_d, wack_q, wack_d, rvalid_q, rvalid_d;
    logic [WIDTH-1:0] rdata_q, rdata_d, rd_mux;

    // Write decode: operand writes are blocked while a sequence runs.
    always_comb begin
        in_d = in_q; w_d = w_q; b_d = b_q; res_d = res_q;
        srst_d = srst_q; err_d = err_q; start_req = 1'b0;
        wack_d = bus.WREQ;
        if (bus.WREQ) begin
            if (bus.WADDR == ADDR_WIDTH'(ADDR_CTRL)) begin
                srst_d    = bus.WDATA[CTRL_SRST];
                start_req = bus.WDATA[CTRL_START] && !srst_q && !bus.WDATA[CTRL_SRST];
            end
            for (int i = 0; i < NUM_INPUTS; i++)
                if (bus.WADDR == ADDR_WIDTH'(IN_BASE + i)) begin
                    if (busy) err_d = 1'b1; else in_d[i] = bus.WDATA;
                end
            for (int k = 0; k < NUM_NEURONS*NUM_INPUTS; k++)
                if (bus.WADDR == ADDR_WIDTH'(WB + k)) begin
                    if (busy) err_d = 1'b1; else w_d[k] = bus.WDATA;
                end
            for (int n = 0; n < NUM_NEURONS; n++)
                if (bus.WADDR == ADDR_WIDTH'(BB + n)) begin
                    if (busy) err_d = 1'b1; else b_d[n] = bus.WDATA;
                end
        end
        if (res_we)
            for (int n = 0; n < NUM_NEURONS; n++)
                if (idx == IDX_W'(n)) res_d[n] = res_data;
        if (srst_q) begin
            for (int n = 0; n < NUM_NEURONS; n++) res_d[n] = '0;
            err_d = 1'b0;
        end
    end

    // Read decode; unmapped addresses read as zero.
    always_comb begin
        rd_mux = '0;
        if (bus.RADDR == ADDR_WIDTH'(ADDR_CTRL)) rd_mux[CTRL_SRST] = srst_q;
        if (bus.RADDR == ADDR_WIDTH'(ADDR_STATUS)) begin
            rd_mux[ST_IDLE] = idle;
            rd_mux[ST_DONE] = st_done;
            rd_mux[ST_OVF]  = st_ovf;
            rd_mux[ST_TO]   = st_to;
            rd_mux[ST_WERR] = err_q;
        end
        for (int i = 0; i < NUM_INPUTS; i++)
            if (bus.RADDR == ADDR_WIDTH'(IN_BASE + i)) rd_mux = in_q[i];
        for (int k = 0; k < NUM_NEURONS*NUM_INPUTS; k++)
            if (bus.RADDR == ADDR_WIDTH'(WB + k)) rd_mux = w_q[k];
        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (bus.RADDR == ADDR_WIDTH'(BB + n)) rd_mux = b_q[n];
            if (bus.RADDR == ADDR_WIDTH'(RB + n)) rd_mux = res_q[n];
        end
        rvalid_d = bus.RREQ;
        rdata_d  = bus.RREQ ? rd_mux : rdata_q;
    end

    // Operand muxes toward the core for the currently selected neuron.
    always_comb begin
        core_weights = '0;
        core_bias    = '0;
        core_values  = '0;
        for (int n = 0; n < NUM_NEURONS; n++)
            if (idx == IDX_W'(n)) begin
                core_bias = b_q[n];
                for (int i = 0; i < NUM_INPUTS; i++)
                    core_weights[i*WIDTH +: WIDTH] = w_q[n*NUM_INPUTS + i];
            end
        for (int i = 0; i < NUM_INPUTS; i++)
            core_values[i*WIDTH +: WIDTH] = in_q[i];
    end

    // Register state update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) in_q[i] <= '0;
            for (int k = 0; k < NUM_NEURONS*NUM_INPUTS; k++) w_q[k] <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                b_q[n]   <= '0;
                res_q[n] <= '0;
            end
            srst_q <= 1'b0; err_q <= 1'b0; wack_q <= 1'b0;
            rvalid_q <= 1'b0; rdata_q <= '0;
        end else begin
            in_q <= in_d; w_q <= w_d; b_q <= b_d; res_q <= res_d;
            srst_q <= srst_d; err_q <= err_d; wack_q <= wack_d;
            rvalid_q <= rvalid_d; rdata_q <= rdata_d;
        end
    end

    assign bus.WACK   = wack_q;
    assign bus.RVALID = rvalid_q;
    assign bus.RDATA  = rdata_q;
    assign soft_reset = srst_q;
endmodule

// File: rtl/neuron_layer_ctrl.sv
// Time-multiplexes one neuron core over NUM_NEURONS channels: issues each
// neuron with a start pulse, collects results, and guards each core
// evaluation with a timeout watchdog.
module neuron_layer_ctrl import neuron_layer_pkg::*; #(
    parameter int NUM_INPUTS     = 2,
    parameter int NUM_NEURONS    = 4,
    parameter int WIDTH          = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        CLK,
    input  logic                        RST,
    neuron_layer_ctrl_if.slave          bus,
    output logic                        CORE_RST,
    output logic [NUM_INPUTS*WIDTH-1:0] CORE_WEIGHTS,
    output logic [WIDTH-1:0]            CORE_BIAS,
    output logic [NUM_INPUTS*WIDTH-1:0] CORE_VALUES,
    output logic                        CORE_START,
    input  logic                        CORE_READY,
    input  logic [WIDTH-1:0]            CORE_VALUE_OUT,
    input  logic                        CORE_VALID_OUT,
    input  logic                        CORE_OVERFLOW,
    output logic                        BUSY,
    output logic                        DONE_IRQ,
    output logic [1:0]                  DBG_STATE
);
    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d, irq_q, irq_d;
    logic             done_q, done_d, ovf_q, ovf_d, to_q, to_d;
    logic             res_we, soft_reset, start_req;

    neuron_layer_regbank #(
        .NUM_INPUTS(NUM_INPUTS), .NUM_NEURONS(NUM_NEURONS), .WIDTH(WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W)
    ) u_regbank (
        .clk(CLK), .rst(RST), .bus(bus),
        .busy(BUSY), .idle(state_q == S_IDLE),
        .st_done(done_q), .st_ovf(ovf_q), .st_to(to_q),
        .idx(idx_q), .res_we(res_we), .res_data(CORE_VALUE_OUT),
        .soft_reset(soft_reset), .start_req(start_req),
        .core_weights(CORE_WEIGHTS), .core_bias(CORE_BIAS), .core_values(CORE_VALUES)
    );

    // Sequencer: issue each neuron, wait for its result or a timeout.
    always_comb begin
        state_d = state_q; idx_d = idx_q; cnt_d = cnt_q;
        start_d = 1'b0; irq_d = 1'b0; res_we = 1'b0;
        done_d = done_q; ovf_d = ovf_q; to_d = to_q;
        if (soft_reset) begin
            state_d = S_IDLE; idx_d = '0; cnt_d = '0;
            done_d = 1'b0; ovf_d = 1'b0; to_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_req) begin
                    idx_d = '0; done_d = 1'b0; ovf_d = 1'b0; to_d = 1'b0;
                    state_d = S_ISSUE;
                end
                S_ISSUE: if (CORE_READY) begin
                    start_d = 1'b1; cnt_d = '0; state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A result arriving on the terminal count still counts.
                    if (CORE_VALID_OUT) begin
                        res_we = 1'b1;
                        ovf_d  = ovf_q | CORE_OVERFLOW;
                        if (idx_q == IDX_W'(NUM_NEURONS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_ISSUE;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        to_d = 1'b1; state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_d = 1'b1; irq_d = 1'b1; state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Sequencer state and sticky status flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE; idx_q <= '0; cnt_q <= '0;
            start_q <= 1'b0; irq_q <= 1'b0;
            done_q <= 1'b0; ovf_q <= 1'b0; to_q <= 1'b0;
        end else begin
            state_q <= state_d; idx_q <= idx_d; cnt_q <= cnt_d;
            start_q <= start_d; irq_q <= irq_d;
            done_q <= done_d; ovf_q <= ovf_d; to_q <= to_d;
        end
    end

    assign CORE_RST   = RST | soft_reset;
    assign CORE_START = start_q;
    assign DONE_IRQ   = irq_q;
    assign BUSY       = (state_q != S_IDLE);
    assign DBG_STATE  = state_q;
endmodule

// File: tb/tb_neuron_layer_ctrl.sv
// Bench for neuron_layer_ctrl with a behavioural core (bias + weight0,
// latency 3, always ready) and a register-level reference model.
module tb_neuron_layer_ctrl;
    localparam int NI = 2, NN = 4, W = 8, AW = 6, CORE_LAT = 3;
    localparam int WB = 4, BB = 12, RB = 16;

    logic CLK = 1'b0, RST = 1'b1;
    neuron_layer_ctrl_if #(.ADDR_WIDTH(AW), .WIDTH(W)) bus_if ();
    logic          CORE_RST, CORE_START, BUSY, DONE_IRQ;
    logic [NI*W-1:0] CORE_WEIGHTS, CORE_VALUES;
    logic [W-1:0]  CORE_BIAS;
    logic          CORE_READY = 1'b1;
    logic [W-1:0]  core_val = '0;
    logic          core_valid = 1'b0, core_ovf = 1'b0;
    logic [1:0]    DBG_STATE;

    neuron_layer_ctrl #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(255)
    ) dut (
        .CLK(CLK), .RST(RST), .bus(bus_if),
        .CORE_RST(CORE_RST), .CORE_WEIGHTS(CORE_WEIGHTS), .CORE_BIAS(CORE_BIAS),
        .CORE_VALUES(CORE_VALUES), .CORE_START(CORE_START), .CORE_READY(CORE_READY),
        .CORE_VALUE_OUT(core_val), .CORE_VALID_OUT(core_valid), .CORE_OVERFLOW(core_ovf),
        .BUSY(BUSY), .DONE_IRQ(DONE_IRQ), .DBG_STATE(DBG_STATE)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    // behavioural core and event counters
    int start_cnt = 0, irq_cnt = 0, st_base = 0, irq_base = 0;
    int drop_sel = -1, ovf_sel = -1;
    logic       pend = 1'b0, pend_ovf = 1'b0, pend_drop = 1'b0;
    logic [1:0] pend_cnt = '0;
    logic [W-1:0] pend_val = '0;

    always @(posedge CLK) begin
        core_valid <= 1'b0;
        core_ovf   <= 1'b0;
        if (CORE_START === 1'b1) start_cnt <= start_cnt + 1;
        if (CORE_RST) begin
            pend <= 1'b0;
        end else if (CORE_START === 1'b1) begin
            pend      <= 1'b1;
            pend_cnt  <= 2'(CORE_LAT - 2);
            pend_val  <= CORE_BIAS + CORE_WEIGHTS[W-1:0];
            pend_ovf  <= ((start_cnt - st_base) == ovf_sel);
            pend_drop <= ((start_cnt - st_base) == drop_sel);
        end else if (pend) begin
            if (pend_cnt == 2'd0) begin
                pend <= 1'b0;
                if (!pend_drop) begin
                    core_valid <= 1'b1;
                    core_ovf   <= pend_ovf;
                    core_val   <= pend_val;
                end
            end else begin
                pend_cnt <= pend_cnt - 2'd1;
            end
        end
    end

    always @(negedge CLK) if (DONE_IRQ === 1'b1) irq_cnt <= irq_cnt + 1;

    // scoreboard counters
    int n_checks = 0, n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // reference model of the register map
    logic [W-1:0] m_in [NI], m_w [NN*NI], m_b [NN], m_res [NN];
    logic m_done, m_ovf, m_to, m_err;

    function automatic void m_reset();
        for (int i = 0; i < NI; i++) m_in[i] = '0;
        for (int k = 0; k < NN*NI; k++) m_w[k] = '0;
        for (int n = 0; n < NN; n++) begin m_b[n] = '0; m_res[n] = '0; end
        m_done = 0; m_ovf = 0; m_to = 0; m_err = 0;
    endfunction

    function automatic logic [W-1:0] m_status();
        return {3'b000, m_err, m_to, m_ovf, m_done, 1'b1};
    endfunction

    function automatic void m_write(input int a, input logic [W-1:0] d, input bit busy);
        if (a >= 2 && a < RB) begin
            if (busy) m_err = 1;
            else if (a < WB) m_in[a-2] = d;
            else if (a < BB) m_w[a-WB] = d;
            else m_b[a-BB] = d;
        end
    endfunction

    function automatic logic [W-1:0] m_read(input int a);
        if (a == 1) return m_status();
        if (a >= 2 && a < WB) return m_in[a-2];
        if (a >= WB && a < BB) return m_w[a-WB];
        if (a >= BB && a < RB) return m_b[a-BB];
        if (a >= RB && a < RB + NN) return m_res[a-RB];
        return '0;
    endfunction

    function automatic void m_seq(input int drop_n, input int ovf_n);
        m_done = 0; m_ovf = 0; m_to = 0;
        for (int n = 0; n < NN; n++) begin
            if (n == drop_n) begin m_to = 1; return; end
            m_res[n] = m_b[n] + m_w[n*NI];
            if (n == ovf_n) m_ovf = 1;
        end
        m_done = 1;
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic reg_write(input int a, input logic [W-1:0] d);
        bus_if.WREQ = 1'b1; bus_if.WADDR = AW'(a); bus_if.WDATA = d;
        tick();
        bus_if.WREQ = 1'b0;
        check("wack", bus_if.WACK, 1);
    endtask

    task automatic reg_read(input int a, output logic [W-1:0] d);
        bus_if.RREQ = 1'b1; bus_if.RADDR = AW'(a);
        tick();
        bus_if.RREQ = 1'b0;
        check("rvalid", bus_if.RVALID, 1);
        d = bus_if.RDATA;
    endtask

    task automatic read_check(input string nm, input int a, input logic [W-1:0] exp);
        logic [W-1:0] d;
        reg_read(a, d);
        check(nm, d, exp);
    endtask

    task automatic seq_start(input int drop_n, input int ovf_n);
        drop_sel = drop_n; ovf_sel = ovf_n;
        st_base = start_cnt; irq_base = irq_cnt;
        reg_write(0, 8'h02);
    endtask

    task automatic seq_wait(output int n);
        n = 0;
        while (!(DONE_IRQ === 1'b1 || BUSY === 1'b0) && n < 600) begin
            tick();
            n++;
        end
        check("seq_bound", n < 600, 1);
    endtask

    task automatic run_seq(input int drop_n, input int ovf_n, output int cyc);
        int n;
        seq_start(drop_n, ovf_n);
        seq_wait(n);
        cyc = n + 1;
        m_seq(drop_n, ovf_n);
        tick(); tick();
    endtask

    typedef struct {
        int           addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, a;
        logic [W-1:0] d;

        vecs[0] = '{2,  8'h5A, 8'h5A};
        vecs[1] = '{3,  8'hA5, 8'hA5};
        vecs[2] = '{4,  8'h10, 8'h10};
        vecs[3] = '{11, 8'h3C, 8'h3C};
        vecs[4] = '{12, 8'h01, 8'h01};
        vecs[5] = '{15, 8'h80, 8'h80};
        vecs[6] = '{16, 8'h33, 8'h00};
        vecs[7] = '{1,  8'hFF, 8'h01};
        vecs[8] = '{20, 8'h77, 8'h00};
        vecs[9] = '{63, 8'hAA, 8'h00};

        bus_if.WREQ = 0; bus_if.WADDR = '0; bus_if.WDATA = '0;
        bus_if.RREQ = 0; bus_if.RADDR = '0;
        m_reset();
        RST = 1'b1;
        repeat (3) tick();
        check("rst_busy", BUSY, 0);
        check("rst_core_rst", CORE_RST, 1);
        check("rst_core_start", CORE_START, 0);
        check("rst_irq", DONE_IRQ, 0);
        check("rst_wack", bus_if.WACK, 0);
        check("rst_rvalid", bus_if.RVALID, 0);
        check("rst_rdata", bus_if.RDATA, 0);
        RST = 1'b0;
        tick();
        check("core_rst_release", CORE_RST, 0);
        read_check("rst_status", 1, 8'h01);

        // register map table
        foreach (vecs[i]) begin
            reg_write(vecs[i].addr, vecs[i].wdata);
            m_write(vecs[i].addr, vecs[i].wdata, 0);
            read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end
        check("core_values", CORE_VALUES, 16'hA55A);
        read_check("unmapped63", 63, 8'h00);
        tick();
        check("rvalid_pulse", bus_if.RVALID, 0);
        check("rdata_hold", bus_if.RDATA, 0);

        // single pass
        for (int n = 0; n < NN; n++) begin
            reg_write(BB + n, 8'(n + 1));   m_write(BB + n, 8'(n + 1), 0);
            reg_write(WB + 2*n, 8'h10);     m_write(WB + 2*n, 8'h10, 0);
        end
        run_seq(-1, -1, cyc);
        check("latency", cyc, 22);
        check("starts", start_cnt - st_base, 4);
        check("irq_once", irq_cnt - irq_base, 1);
        for (int n = 0; n < NN; n++) read_check($sformatf("pass_res%0d", n), RB + n, 8'(8'h11 + n));
        read_check("pass_status", 1, 8'h03);

        // overflow on neuron 2, then clean rerun
        run_seq(-1, 2, cyc);
        read_check("ovf_status", 1, 8'h07);
        run_seq(-1, -1, cyc);
        read_check("rerun_status", 1, 8'h03);

        // timeout on neuron 1
        run_seq(1, -1, cyc);
        check("timeout_cycles", cyc, 262);
        check("timeout_busy", BUSY, 0);
        check("timeout_no_irq", irq_cnt - irq_base, 0);
        read_check("timeout_status", 1, 8'h09);
        read_check("timeout_res1", RB + 1, 8'h12);
        read_check("timeout_res0", RB, m_res[0]);

        // busy protection
        seq_start(-1, -1);
        tick(); tick();
        reg_write(BB, 8'h7F); m_write(BB, 8'h7F, 1);
        reg_write(0, 8'h02);
        seq_wait(cyc);
        m_seq(-1, -1);
        tick(); tick();
        check("busy_starts", start_cnt - st_base, 4);
        check("busy_irq", irq_cnt - irq_base, 1);
        read_check("busy_bias0", BB, 8'h01);
        read_check("busy_status", 1, 8'h13);

        // soft reset mid-WAIT
        seq_start(-1, -1);
        tick(); tick(); tick();
        reg_write(0, 8'h01);
        check("srst_core_rst", CORE_RST, 1);
        tick();
        check("srst_busy", BUSY, 0);
        for (int n = 0; n < NN; n++) m_res[n] = '0;
        m_done = 0; m_ovf = 0; m_to = 0; m_err = 0;
        for (int n = 0; n < NN; n++) read_check($sformatf("srst_res%0d", n), RB + n, 8'h00);
        read_check("srst_w00", WB, m_w[0]);
        read_check("srst_status", 1, 8'h01);
        reg_write(0, 8'h03);
        tick();
        check("srst_start_ignored", BUSY, 0);
        reg_write(0, 8'h00);
        check("srst_release", CORE_RST, 0);
        run_seq(-1, -1, cyc);
        check("srst_latency", cyc, 22);
        for (int n = 0; n < NN; n++) read_check($sformatf("srst_run_res%0d", n), RB + n, m_res[n]);

        // randomized register traffic and a sequence against the model
        for (int k = 0; k < 30; k++) begin
            a = $urandom_range(1, 63);
            d = 8'($urandom_range(0, 255));
            reg_write(a, d);
            m_write(a, d, 0);
        end
        for (int k = 0; k < 20; k++) begin
            a = $urandom_range(0, 63);
            read_check($sformatf("rand_rd_a%0d", a), a, m_read(a));
        end
        check("rand_core_values", CORE_VALUES, {m_in[1], m_in[0]});
        run_seq(-1, -1, cyc);
        for (int n = 0; n < NN; n++) read_check($sformatf("rand_res%0d", n), RB + n, m_res[n]);
        read_check("rand_status", 1, m_status());

        // hard reset mid-sequence
        reg_write(BB, 8'h55); m_write(BB, 8'h55, 0);
        seq_start(-1, -1);
        tick(); tick(); tick();
        reg_read(BB, d);
        check("pre_rst_rdata", d, 8'h55);
        RST = 1'b1;
        tick();
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_start", CORE_START, 0);
        check("mid_rst_irq", DONE_IRQ, 0);
        check("mid_rst_wack", bus_if.WACK, 0);
        check("mid_rst_rvalid", bus_if.RVALID, 0);
        check("mid_rst_rdata", bus_if.RDATA, 0);
        check("mid_rst_core_rst", CORE_RST, 1);
        RST = 1'b0;
        m_reset();
        tick();
        read_check("post_rst_status", 1, 8'h01);
        read_check("post_rst_bias0", BB, m_b[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/neuron_layer_ctrl.md
Name: neuron_layer_ctrl

Overview:
- Successor to the single-neuron wrapper. Register-mapped controller that time-multiplexes one external neuron core across NUM_NEURONS output channels, each with NUM_INPUTS inputs.
- Holds the input vector, per-neuron weights and biases, and a result bank. Sequences the core with a start/valid handshake.
- Adds what the single-neuron wrapper lacks: multi-channel sequencing, sticky overflow, a core-timeout watchdog and a completion pulse.
- Sits between the SCI slave network interface (request/ack register port) and the neuron core.

Parameters:
- NUM_INPUTS, 2, inputs per neuron (≥1)
- NUM_NEURONS, 4, output channels (≥1)
- WIDTH, 8, data/register width, signed fixed point
- ADDR_WIDTH, 6, register address width; must hold 2+NI+NN*NI+2*NN words
- TIMEOUT_CYCLES, 255, max cycles to wait for CORE_VALID_OUT

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- WREQ  in  1  register write request
- WADDR  in  ADDR_WIDTH  write address
- WDATA  in  WIDTH  write data
- WACK  out  1  write acknowledge pulse
- RREQ  in  1  register read request
- RADDR  in  ADDR_WIDTH  read address
- RDATA  out  WIDTH  read data
- RVALID  out  1  read data valid pulse
- CORE_RST  out  1  core reset, active-high (RST | soft_reset)
- CORE_WEIGHTS  out  NUM_INPUTS*WIDTH  weights of current neuron, input i at [i*WIDTH+:WIDTH]
- CORE_BIAS  out  WIDTH  bias of current neuron
- CORE_VALUES  out  NUM_INPUTS*WIDTH  input vector
- CORE_START  out  1  one-cycle start pulse
- CORE_READY  in  1  core can accept a start
- CORE_VALUE_OUT  in  WIDTH  core result
- CORE_VALID_OUT  in  1  result valid pulse
- CORE_OVERFLOW  in  1  overflow, qualified by CORE_VALID_OUT
- BUSY  out  1  sequence in progress
- DONE_IRQ  out  1  one-cycle pulse on successful completion

Behaviour:
- Register map (word addresses). Offsets W=2+NI, B=W+NN*NI, R=B+NN.
  - 0 CTRL RW: [0] soft_reset (level); [1] start (write-1 triggers, reads 0).
  - 1 STATUS RO: [0] idle; [1] done (sticky); [2] overflow (sticky); [3] timeout (sticky); [4] wr_err (sticky).
  - 2..2+NI-1 input i.
  - W+n*NI+i weight (n,i).
  - B+n bias n.
  - R+n result n, RO.
- Writes:
  - WACK pulses exactly 1 cycle after WREQ, for every write including unmapped and RO addresses.
  - Unmapped and RO writes: no effect.
  - Writes to input/weight/bias while BUSY: ignored, set wr_err.
- Reads:
  - RVALID pulses 1 cycle after RREQ; RDATA holds until the next read.
  - Unmapped reads return 0.
- Reset (RST=1):
  - All registers and results 0; FSM in IDLE.
  - WACK, RVALID, RDATA, CORE_START, BUSY, DONE_IRQ all 0; CORE_RST=1.
- Soft reset (CTRL[0]=1):
  - FSM forced to IDLE; STATUS sticky bits and results cleared; CORE_RST=1.
  - Inputs, weights and biases preserved.
  - Start writes ignored while soft_reset is set.
- FSM:
  - IDLE: on a write to CTRL with WDATA[1]=1, set idx=0, clear done/overflow/timeout, go to ISSUE. BUSY rises the cycle after WREQ.
  - ISSUE: drive CORE_WEIGHTS/CORE_BIAS for idx. When CORE_READY=1, pulse CORE_START for 1 cycle, clear the timeout counter, go to WAIT.
  - WAIT: on CORE_VALID_OUT, store result[idx] and OR CORE_OVERFLOW into overflow. If idx=NN-1 go to DONE, else idx+1 and go to ISSUE. If the counter reaches TIMEOUT_CYCLES first, set timeout and go to IDLE (done stays 0).
  - DONE: set done, pulse DONE_IRQ, go to IDLE.
- Start received while BUSY: ignored.
- CORE_VALID_OUT outside WAIT: ignored.
- Simultaneous CORE_VALID_OUT and timeout terminal count: the valid wins.
- CORE_VALUES and the bias/weight mux are combinational from registers; idx is registered.
- Minimum sequence latency: from WREQ(start) to DONE_IRQ is 2 + NN*(2 + core latency) cycles.

Decomposition:
- Shared package neuron_layer_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT, DONE).
  - CTRL/STATUS bit indices.
  - Address-offset functions W_BASE/B_BASE/R_BASE(NI,NN).
- One sub-module: neuron_layer_regbank. It holds the register file, address decode, WACK/RVALID and wr_err.
- The FSM, index and timeout counter stay in the top.

Test Plan:
All scenarios use NI=2, NN=4, WIDTH=8. The bench core returns bias+weight0, latency 3, READY=1.
- Single pass: biases 1,2,3,4, weights0 all 0x10, start → CORE_START×4; results 0x11,0x12,0x13,0x14; STATUS=0x03; one DONE_IRQ.
- Overflow: core asserts CORE_OVERFLOW on neuron 2 only → STATUS[2]=1 after DONE; a second start clears it; the clean rerun gives STATUS=0x03.
- Timeout: core never returns VALID for neuron 1 → after 255 WAIT cycles STATUS=0x09, BUSY=0, no DONE_IRQ, result1 unchanged.
- Busy protection: write bias0=0x7F and a second start mid-sequence → WACK still pulses, bias0 unchanged, STATUS[4]=1, exactly 4 CORE_STARTs.
- Soft reset mid-WAIT: set CTRL[0] → BUSY=0, CORE_RST=1, results 0, weights readback intact; clear CTRL[0] and start → normal completion.
- Register port: read unmapped address 63 → RDATA=0, RVALID 1 cycle later; RST pulse mid-sequence → all outputs at reset values the next cycle.
